cache_fill_fsm: RTL and testbench

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

---
 rtl/cache_fill_fsm_pkg.sv | 17 +
 rtl/cache_fill_fsm_fill_counter.sv | 37 +++
 rtl/cache_fill_fsm.sv | 109 ++++++++++
 tb/tb_cache_fill_fsm.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the I-cache block fill controller: state encoding,
// block geometry and datapath widths.
package cache_fill_fsm_pkg;

  localparam int WORDS_PER_BLOCK_DEFAULT = 8;
  localparam int WORD_W      = 16;
  localparam int ADDR_W      = 16;
  localparam int WORD_SEL_W  = 3;
  localparam int ISSUE_CNT_W = WORD_SEL_W + 1;
  localparam int BASE_W      = ADDR_W - WORD_SEL_W - 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Up-counter with synchronous clear and count enable; reset and clear both
// return it to zero, clear taking priority over enable.
module fill_counter
  import cache_fill_fsm_pkg::*;
#(
  parameter int WIDTH = ISSUE_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en) begin
      count_next = count_reg + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/cache_fill_fsm.sv
// I-cache miss fill controller: issues one read per word of the missing block
// and writes words back as memory_data_valid arrives, whatever the latency.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_detected,
  input  logic [ADDR_W-1:0]     miss_address,
  input  logic [WORD_W-1:0]     memory_data,
  input  logic                  memory_data_valid,
  output logic                  fsm_busy,
  output logic                  mem_en,
  output logic [ADDR_W-1:0]     memory_address,
  output logic                  write_data_array,
  output logic [WORD_SEL_W-1:0] word_sel,
  output logic                  write_tag_array,
  output logic [WORD_W-1:0]     fill_data
);

  fill_state_e             state_reg;
  fill_state_e             state_next;
  logic [BASE_W-1:0]       base_reg;
  logic [BASE_W-1:0]       base_next;
  logic [ISSUE_CNT_W-1:0]  issue_cnt;
  logic [WORD_SEL_W-1:0]   recv_cnt;

  logic in_idle;
  logic in_fill;
  logic start_fill;
  logic issue_en;
  logic recv_en;
  logic last_word;
  logic unused_miss_offset;

  assign in_idle    = (state_reg == ST_IDLE);
  assign in_fill    = (state_reg == ST_FILL);
  assign start_fill = in_idle & miss_detected;

  // Request/write strobes are held off while reset is asserted, even if the
  // state register still reads FILL in that cycle.
  assign issue_en  = in_fill & rst_n & (issue_cnt != ISSUE_CNT_W'(WORDS_PER_BLOCK));
  assign recv_en   = in_fill & rst_n & memory_data_valid;
  assign last_word = recv_en & (recv_cnt == WORD_SEL_W'(WORDS_PER_BLOCK - 1));

  // Byte offset within the block is regenerated from the issue counter.
  assign unused_miss_offset = ^miss_address[WORD_SEL_W:0];

  always_comb begin
    state_next = state_reg;
    base_next  = base_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (miss_detected) begin
          state_next = ST_FILL;
          base_next  = miss_address[ADDR_W-1:WORD_SEL_W+1];
        end
      end
      ST_FILL: begin
        if (last_word) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      base_reg  <= '0;
    end else begin
      state_reg <= state_next;
      base_reg  <= base_next;
    end
  end

  fill_counter #(
    .WIDTH (ISSUE_CNT_W)
  ) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_fill),
    .en    (issue_en),
    .count (issue_cnt)
  );

  fill_counter #(
    .WIDTH (WORD_SEL_W)
  ) u_recv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_fill),
    .en    (recv_en),
    .count (recv_cnt)
  );

  // Busy is Mealy on the miss so the pipeline stalls in the miss cycle itself.
  assign fsm_busy         = start_fill | (in_fill & rst_n);
  assign mem_en           = issue_en;
  assign memory_address   = {base_reg, issue_cnt[WORD_SEL_W-1:0], 1'b0};
  assign write_data_array = recv_en;
  assign word_sel         = recv_cnt;
  assign write_tag_array  = last_word;
  assign fill_data        = memory_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: stimulus pushes expected reads, writes and
// tag writes into queues; a negedge monitor pops and compares them.
module tb_cache_fill_fsm;

  logic        clk;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  word_sel;
  logic        write_tag_array;
  logic [15:0] fill_data;

  cache_fill_fsm #(
    .WORDS_PER_BLOCK (8)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_en            (mem_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .word_sel          (word_sel),
    .write_tag_array   (write_tag_array),
    .fill_data         (fill_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] val;
    logic [2:0]  sel;
  } exp_t;

  exp_t q_req[$];
  exp_t q_wr[$];
  exp_t q_tag[$];

  int n_cmp = 0;
  int n_bad = 0;
  int vofs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] data_for(input logic [15:0] a, input int j);
    return a ^ (16'h5A00 + 16'(j));
  endfunction

  // Monitor: every strobe must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (mem_en) begin
      if (q_req.size() == 0) chk("unexpected_mem_en", 32'd1, 32'd0);
      else begin
        e = q_req.pop_front();
        $display("read  cyc=%0d addr=0x%04h", cyc, memory_address);
        chk("req_cycle", cyc, e.cyc);
        chk("req_addr", {16'h0, memory_address}, {16'h0, e.val});
      end
    end
    if (write_data_array) begin
      if (q_wr.size() == 0) chk("unexpected_data_write", 32'd1, 32'd0);
      else begin
        e = q_wr.pop_front();
        $display("write cyc=%0d sel=%0d data=0x%04h", cyc, word_sel, fill_data);
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_word_sel", {29'h0, word_sel}, {29'h0, e.sel});
        chk("wr_fill_data", {16'h0, fill_data}, {16'h0, e.val});
      end
    end
    if (write_tag_array) begin
      if (q_tag.size() == 0) chk("unexpected_tag_write", 32'd1, 32'd0);
      else begin
        e = q_tag.pop_front();
        $display("tag   cyc=%0d", cyc);
        chk("tag_cycle", cyc, e.cyc);
      end
    end
  end

  // One fill: miss at rel 0, valids at vofs[], optional reset at rst_rel,
  // optional foreign miss during the fill, then `tail` idle cycles.
  task automatic run_fill(input logic [15:0] addr, input int rst_rel, input int tail,
                          input bit miss_in_fill);
    int   last_rel, end_rel, base_cyc, k;
    bit   v;
    int   vidx;
    exp_t e;
    last_rel = (rst_rel >= 0) ? rst_rel - 1 : vofs[7];
    end_rel  = (rst_rel >= 0) ? vofs[7] : vofs[7] + tail;
    @(posedge clk); #1;
    base_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      if (i + 1 <= last_rel) begin
        e.cyc = base_cyc + i + 1;
        e.val = {addr[15:4], 3'(i), 1'b0};
        e.sel = 3'd0;
        q_req.push_back(e);
      end
    end
    k = 0;
    for (int j = 0; j < 8; j++) begin
      if (vofs[j] >= 1 && vofs[j] <= last_rel) begin
        e.cyc = base_cyc + vofs[j];
        e.val = data_for(addr, j);
        e.sel = 3'(k);
        q_wr.push_back(e);
        k++;
      end
    end
    if (rst_rel < 0) begin
      e.cyc = base_cyc + vofs[7];
      e.val = 16'h0;
      e.sel = 3'd0;
      q_tag.push_back(e);
    end
    for (int rel = 0; rel <= end_rel; rel++) begin
      if (rel > 0) begin
        @(posedge clk); #1;
      end
      v = 1'b0;
      vidx = 0;
      for (int j = 0; j < 8; j++) begin
        if (vofs[j] == rel) begin
          v = 1'b1;
          vidx = j;
        end
      end
      rst_n             = (rel == rst_rel) ? 1'b0 : 1'b1;
      miss_detected     = (rel == 0) || (miss_in_fill && rel >= 2 && rel <= 4);
      miss_address      = (rel == 0) ? addr : 16'hFFF0;
      memory_data_valid = v;
      memory_data       = v ? data_for(addr, vidx) : 16'h0000;
      @(negedge clk);
      if (rel != rst_rel)
        chk("fsm_busy", {31'h0, fsm_busy}, {31'h0, (rel <= last_rel)});
    end
  endtask

  task automatic idle(input int n, input bit stray_valid);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst_n             = 1'b1;
      miss_detected     = 1'b0;
      miss_address      = 16'h0000;
      memory_data_valid = stray_valid;
      memory_data       = 16'hBAD0;
      @(negedge clk);
      chk("idle_busy", {31'h0, fsm_busy}, 32'd0);
      chk("idle_no_write", {31'h0, write_data_array}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n             = 1'b0;
    miss_detected     = 1'b0;
    miss_address      = 16'h0;
    memory_data       = 16'h0;
    memory_data_valid = 1'b1;

    // Reset behaviour: strobes low even with a valid, busy follows the miss.
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_busy", {31'h0, fsm_busy}, 32'd0);
    chk("rst_mem_en", {31'h0, mem_en}, 32'd0);
    chk("rst_write_data", {31'h0, write_data_array}, 32'd0);
    chk("rst_write_tag", {31'h0, write_tag_array}, 32'd0);
    @(posedge clk); #1;
    miss_detected = 1'b1;
    miss_address  = 16'h5550;
    @(negedge clk);
    chk("rst_busy_on_miss", {31'h0, fsm_busy}, 32'd1);
    chk("rst_mem_en_on_miss", {31'h0, mem_en}, 32'd0);
    idle(2, 1'b0);

    // Fixed 4-cycle latency at 0x1234.
    vofs = '{5, 6, 7, 8, 9, 10, 11, 12};
    run_fill(16'h1234, -1, 1, 1'b0);
    idle(1, 1'b0);

    // Irregular valid gaps.
    vofs = '{6, 7, 10, 15, 16, 17, 20, 25};
    run_fill(16'h4560, -1, 2, 1'b0);

    // Foreign miss during a fill is ignored.
    vofs = '{5, 6, 7, 8, 9, 10, 11, 12};
    run_fill(16'h2A00, -1, 2, 1'b0);
    run_fill(16'h2A00, -1, 2, 1'b1);

    // Spurious valids in IDLE.
    idle(3, 1'b1);

    // Reset at cycle 6 of a fill; later valids land in IDLE.
    vofs = '{5, 6, 7, 8, 9, 10, 11, 12};
    run_fill(16'h0770, 6, 0, 1'b0);
    idle(2, 1'b0);

    // Back-to-back fills, second miss in the cycle after the tag write.
    vofs = '{5, 6, 7, 8, 9, 10, 11, 12};
    run_fill(16'h0000, -1, 0, 1'b0);
    run_fill(16'h0010, -1, 2, 1'b0);
    idle(2, 1'b0);

    chk("pending_reads", q_req.size(), 32'd0);
    chk("pending_writes", q_wr.size(), 32'd0);
    chk("pending_tags", q_tag.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
